// File: rtl/ttl74x461_seq_if.sv
// ----------------------------------------------------------------------------
// ttl74x461_seq_if : command handshake and counter-control bundle for ttl74x461_seq
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ttl74x461_seq_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cnt_CO_n;
    logic [1:0]       cnt_m;
    logic             cnt_CI_n;
    logic [WIDTH-1:0] cnt_D;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cnt_CO_n,
        input  cmd_ready, cnt_m, cnt_CI_n, cnt_D, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cnt_CO_n,
        output cmd_ready, cnt_m, cnt_CI_n, cnt_D, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/ttl74x461_seq.sv
// ----------------------------------------------------------------------------
// ttl74x461_seq : one-shot / periodic sequencer driving a 74x461-style counter.
// Optional count-enable prescaler: define TTL74X461_SEQ_PRESCALE_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ttl74x461_seq #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 3
) (
    input  logic             clk,
    input  logic             CLR_n,
    ttl74x461_seq_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_LOAD  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [1:0] c_op_clear = 2'b00;
    localparam logic [1:0] c_op_abort = 2'b11;
    localparam logic [1:0] c_op_per   = 2'b10;

    localparam logic [1:0] c_m_clear = 2'b00;
    localparam logic [1:0] c_m_hold  = 2'b01;
    localparam logic [1:0] c_m_load  = 2'b10;
    localparam logic [1:0] c_m_count = 2'b11;

    state_t           r_state;
    state_t           w_next;
    state_t           w_cmd_next;
    logic [WIDTH-1:0] r_reload;
    logic             r_periodic;
    logic             r_done;
    logic             w_ready;
    logic             w_accept;
    logic             w_tick;
    logic             w_expire;
    logic             w_is_load_op;
    logic [1:0]       w_m;
    logic             w_ci_n;

    assign w_ready      = (r_state == S_IDLE) || (r_state == S_RUN);
    assign w_accept     = bus.cmd_valid && w_ready;
    assign w_is_load_op = bus.cmd_op[1] ^ bus.cmd_op[0];
    // A command accepted in the expiry cycle takes priority over the expiry.
    assign w_expire     = (r_state == S_RUN) && !bus.cnt_CO_n && w_tick && !w_accept;

`ifdef TTL74X461_SEQ_PRESCALE_EN
    localparam logic [7:0] c_prescale = 8'(PRESCALE);

    logic [7:0] r_pre;

    assign w_tick = (r_pre == c_prescale);

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            r_pre <= 8'd0;
        end else if (r_state == S_LOAD) begin
            r_pre <= 8'd0;
        end else if (r_state == S_RUN) begin
            r_pre <= w_tick ? 8'd0 : r_pre + 8'd1;
        end
    end
`else
    logic w_unused_prescale;

    assign w_tick            = 1'b1;
    assign w_unused_prescale = ^PRESCALE;
`endif

    always_comb begin
        w_cmd_next = S_LOAD;
        w_next     = r_state;
        w_m        = c_m_hold;
        w_ci_n     = 1'b1;

        case (bus.cmd_op)
            c_op_clear: w_cmd_next = S_CLEAR;
            c_op_abort: w_cmd_next = S_IDLE;
            default:    w_cmd_next = S_LOAD;
        endcase

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_cmd_next;
                end
            end
            S_CLEAR: begin
                w_m    = c_m_clear;
                w_next = S_IDLE;
            end
            S_LOAD: begin
                w_m    = c_m_load;
                w_next = S_RUN;
            end
            S_RUN: begin
                w_m    = c_m_count;
                w_ci_n = ~w_tick;
                if (w_accept) begin
                    w_next = w_cmd_next;
                end else if (w_expire) begin
                    // Periodic reload is combinational from carry so the period stays exact.
                    if (r_periodic) begin
                        w_m = c_m_load;
                    end else begin
                        w_m    = c_m_hold;
                        w_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            r_reload   <= '0;
            r_periodic <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_expire;
            if (w_accept && w_is_load_op) begin
                r_reload   <= bus.cmd_data;
                r_periodic <= (bus.cmd_op == c_op_per);
            end
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.cnt_m     = w_m;
    assign bus.cnt_CI_n  = w_ci_n;
    assign bus.cnt_D     = r_reload;
    assign bus.busy      = (r_state == S_LOAD) || (r_state == S_RUN);
    assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ttl74x461_seq.sv
// ----------------------------------------------------------------------------
// tb_ttl74x461_seq : bench for ttl74x461_seq with a behavioural 8-bit counter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ttl74x461_seq;
    localparam int TB_PRESCALE = 1;
`ifdef TTL74X461_SEQ_PRESCALE_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    localparam int PH_IDLE  = 0;
    localparam int PH_CLEAR = 1;
    localparam int PH_LOAD  = 2;
    localparam int PH_RUN   = 3;

    typedef struct {
        bit       v;
        bit [1:0] op;
        bit [7:0] d;
        bit [1:0] m;
        bit       done;
        bit       busy;
        bit       ready;
        bit [7:0] q;
    } vec_t;

    typedef struct {
        bit [1:0] m;
        bit       ci_n;
        bit [7:0] dd;
        bit       busy;
        bit       done;
        bit       ready;
        bit [7:0] q;
    } obs_t;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [7:0] q = 8'h00;

    int errors = 0;
    int checks = 0;

    int       m_phase;
    bit [7:0] m_reload;
    bit       m_periodic;
    int       m_pre;
    bit       m_done;

    always #5 clk = ~clk;

    ttl74x461_seq_if #(.WIDTH(8)) bus ();

    ttl74x461_seq #(.WIDTH(8), .PRESCALE(TB_PRESCALE)) dut (
        .clk   (clk),
        .CLR_n (clr_n),
        .bus   (bus)
    );

    // Behavioural counter: not affected by the sequencer reset.
    assign bus.cnt_CO_n = ~(&q);
    always @(posedge clk) begin
        case (bus.cnt_m)
            2'b00:   q <= 8'h00;
            2'b10:   q <= bus.cnt_D;
            2'b11:   if (!bus.cnt_CI_n) q <= q + 8'd1;
            default: ;
        endcase
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t row(input bit v, input bit [1:0] op, input bit [7:0] d,
                                 input bit [1:0] m, input bit dn, input bit b,
                                 input bit r, input bit [7:0] qq);
        vec_t x;
        x.v = v; x.op = op; x.d = d; x.m = m;
        x.done = dn; x.busy = b; x.ready = r; x.q = qq;
        return x;
    endfunction

    task automatic model_reset();
        m_phase    = PH_IDLE;
        m_reload   = 8'h00;
        m_periodic = 1'b0;
        m_pre      = 0;
        m_done     = 1'b0;
    endtask

    // One clock: drive at negedge, compare against the model, advance the model.
    task automatic cycle(input bit v, input bit [1:0] op, input bit [7:0] d, output obs_t o);
        bit       ready;
        bit       acc;
        bit       tick;
        bit       expire;
        bit [1:0] em;
        @(negedge clk);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        #1;
        o.m = bus.cnt_m; o.ci_n = bus.cnt_CI_n; o.dd = bus.cnt_D;
        o.busy = bus.busy; o.done = bus.done; o.ready = bus.cmd_ready; o.q = q;

        ready  = (m_phase == PH_IDLE) || (m_phase == PH_RUN);
        acc    = v && ready;
        tick   = !PRE_EN || (m_pre == TB_PRESCALE);
        expire = (m_phase == PH_RUN) && (o.q == 8'hFF) && tick && !acc;
        case (m_phase)
            PH_IDLE:  em = 2'b01;
            PH_CLEAR: em = 2'b00;
            PH_LOAD:  em = 2'b10;
            default:  em = expire ? (m_periodic ? 2'b10 : 2'b01) : 2'b11;
        endcase

        chk("cnt_m", int'(o.m), int'(em));
        chk("cmd_ready", int'(o.ready), int'(ready));
        chk("busy", int'(o.busy), int'(m_phase == PH_LOAD || m_phase == PH_RUN));
        chk("done", int'(o.done), int'(m_done));
        chk("cnt_D", int'(o.dd), int'(m_reload));
        if (m_phase == PH_IDLE) chk("cnt_CI_n idle", int'(o.ci_n), 1);
        else if (m_phase == PH_RUN) chk("cnt_CI_n run", int'(o.ci_n), int'(!tick));

        @(posedge clk);
        m_done = expire;
        if (m_phase == PH_LOAD) m_pre = 0;
        else if (m_phase == PH_RUN) m_pre = tick ? 0 : m_pre + 1;
        if (acc) begin
            if (op == 2'b01 || op == 2'b10) begin
                m_reload   = d;
                m_periodic = (op == 2'b10);
            end
            m_phase = (op == 2'b00) ? PH_CLEAR : (op == 2'b11) ? PH_IDLE : PH_LOAD;
        end else begin
            case (m_phase)
                PH_CLEAR: m_phase = PH_IDLE;
                PH_LOAD:  m_phase = PH_RUN;
                PH_RUN:   if (expire && !m_periodic) m_phase = PH_IDLE;
                default:  ;
            endcase
        end
        #1;
    endtask

    initial begin
        vec_t tbl[$];
        obs_t o;
        bit   found;
        bit   tick_now;

        clr_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'h00;
        model_reset();

        #1;
        chk("reset cnt_m", int'(bus.cnt_m), 1);
        chk("reset cnt_CI_n", int'(bus.cnt_CI_n), 1);
        chk("reset cnt_D", int'(bus.cnt_D), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset cmd_ready", int'(bus.cmd_ready), 1);

        repeat (2) @(posedge clk);
        #2 clr_n = 1'b1;

`ifdef TTL74X461_SEQ_PRESCALE_EN
        tbl.push_back(row(1, 2'b01, 8'hFE, 2'b01, 0, 0, 1, 8'h00));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b10, 0, 1, 0, 8'h00));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b11, 0, 1, 1, 8'hFE));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b11, 0, 1, 1, 8'hFE));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b11, 0, 1, 1, 8'hFF));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b01, 0, 1, 1, 8'hFF));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b01, 1, 0, 1, 8'hFF));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b01, 0, 0, 1, 8'hFF));
`else
        // One-shot 0xFC
        tbl.push_back(row(1, 2'b01, 8'hFC, 2'b01, 0, 0, 1, 8'h00));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b10, 0, 1, 0, 8'h00));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b11, 0, 1, 1, 8'hFC));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b11, 0, 1, 1, 8'hFD));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b11, 0, 1, 1, 8'hFE));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b01, 0, 1, 1, 8'hFF));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b01, 1, 0, 1, 8'hFF));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b01, 0, 0, 1, 8'hFF));
        // Periodic 0xFE, then abort landing on the expiry cycle (command wins)
        tbl.push_back(row(1, 2'b10, 8'hFE, 2'b01, 0, 0, 1, 8'hFF));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b10, 0, 1, 0, 8'hFF));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b11, 0, 1, 1, 8'hFE));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b10, 0, 1, 1, 8'hFF));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b11, 1, 1, 1, 8'hFE));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b10, 0, 1, 1, 8'hFF));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b11, 1, 1, 1, 8'hFE));
        tbl.push_back(row(1, 2'b11, 8'h00, 2'b11, 0, 1, 1, 8'hFF));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b01, 0, 0, 1, 8'h00));
        // Bring Q to 0x55, then clear
        tbl.push_back(row(1, 2'b01, 8'h54, 2'b01, 0, 0, 1, 8'h00));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b10, 0, 1, 0, 8'h00));
        tbl.push_back(row(1, 2'b11, 8'h00, 2'b11, 0, 1, 1, 8'h54));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b01, 0, 0, 1, 8'h55));
        tbl.push_back(row(1, 2'b00, 8'h00, 2'b01, 0, 0, 1, 8'h55));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 8'h55));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b01, 0, 0, 1, 8'h00));
        // Retrigger a running one-shot with periodic 0xFD
        tbl.push_back(row(1, 2'b01, 8'hF0, 2'b01, 0, 0, 1, 8'h00));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b10, 0, 1, 0, 8'h00));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b11, 0, 1, 1, 8'hF0));
        tbl.push_back(row(1, 2'b10, 8'hFD, 2'b11, 0, 1, 1, 8'hF1));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b10, 0, 1, 0, 8'hF2));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b11, 0, 1, 1, 8'hFD));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b11, 0, 1, 1, 8'hFE));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b10, 0, 1, 1, 8'hFF));
        tbl.push_back(row(0, 2'b00, 8'h00, 2'b11, 1, 1, 1, 8'hFD));
`endif

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].op, tbl[i].d, o);
            chk($sformatf("tbl[%0d] cnt_m", i), int'(o.m), int'(tbl[i].m));
            chk($sformatf("tbl[%0d] done", i), int'(o.done), int'(tbl[i].done));
            chk($sformatf("tbl[%0d] busy", i), int'(o.busy), int'(tbl[i].busy));
            chk($sformatf("tbl[%0d] cmd_ready", i), int'(o.ready), int'(tbl[i].ready));
            chk($sformatf("tbl[%0d] Q", i), int'(o.q), int'(tbl[i].q));
        end

        // Periodic 0x00, abort on the counting edge into 0x10
        cycle(1, 2'b11, 8'h00, o);
        cycle(1, 2'b10, 8'h00, o);
        found = 1'b0;
        for (int n = 0; n < 600 && !found; n++) begin
            cycle(0, 2'b00, 8'h00, o);
            tick_now = !PRE_EN || (m_pre == TB_PRESCALE);
            found = (q == 8'h0F) && (m_phase == PH_RUN) && tick_now;
        end
        chk("wait Q=0F", int'(found), 1);
        cycle(1, 2'b11, 8'h00, o);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 2'b00, 8'h00, o);
            chk("abort cnt_m", int'(o.m), 1);
            chk("abort Q hold", int'(o.q), 8'h10);
            chk("abort no done", int'(o.done), 0);
        end

        // Asynchronous reset in the middle of a periodic run
        cycle(1, 2'b10, 8'h00, o);
        found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            cycle(0, 2'b00, 8'h00, o);
            found = (q == 8'h80);
        end
        chk("wait Q=80", int'(found), 1);
        #1 clr_n = 1'b0;
        #1;
        chk("midrun cnt_m", int'(bus.cnt_m), 1);
        chk("midrun cnt_CI_n", int'(bus.cnt_CI_n), 1);
        chk("midrun cnt_D", int'(bus.cnt_D), 0);
        chk("midrun busy", int'(bus.busy), 0);
        chk("midrun done", int'(bus.done), 0);
        chk("midrun cmd_ready", int'(bus.cmd_ready), 1);
        model_reset();
        @(posedge clk);
        #1;
        chk("midrun Q frozen", int'(q), 8'h80);
        chk("midrun done held", int'(bus.done), 0);
        #1 clr_n = 1'b1;
        cycle(1, 2'b01, 8'hFC, o);
        chk("first cmd ready", int'(o.ready), 1);
        cycle(0, 2'b00, 8'h00, o);
        chk("first cmd load", int'(o.m), 2);

        // Randomised traffic against the reference model
        for (int n = 0; n < 800; n++) begin
            bit       rv;
            bit [1:0] rop;
            bit [7:0] rd;
            rv  = ($urandom % 5) == 0;
            rop = 2'($urandom % 4);
            rd  = (($urandom % 4) != 0) ? 8'($urandom_range(255, 240)) : 8'($urandom);
            cycle(rv, rop, rd, o);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ttl74x461_seq.md
TTL74X461_SEQ -- requirements
Module: ttl74x461_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the controlled counter and of the load data.
REQ-002 SHALL have parameter PRESCALE, default 3: count-enable divide value, used only with the Configuration macro.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block's only clock.
REQ-004 SHALL have port CLR_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accept.
REQ-007 SHALL have port cmd_op  input  2  command: 00 clear, 01 one-shot, 10 periodic, 11 abort.
REQ-008 SHALL have port cmd_data  input  WIDTH  load value for the counter.
REQ-009 SHALL have port cnt_CO_n  input  1  counter ripple carry, low at all-ones.
REQ-010 SHALL have port cnt_m  output  2  counter instruction {m1,m0}: 00 clear, 01 hold, 10 load, 11 count.
REQ-011 SHALL have port cnt_CI_n  output  1  counter carry-in, active low.
REQ-012 SHALL have port cnt_D  output  WIDTH  counter parallel-load data, always equal to the reload register.
REQ-013 SHALL have port busy  output  1  high in states LOAD and RUN.
REQ-014 SHALL have port done  output  1  registered one-cycle expiry pulse.

Function
REQ-015 SHALL implement states IDLE, CLEAR, LOAD and RUN.
REQ-016 SHALL accept a command when cmd_valid and cmd_ready are both high; cmd_ready SHALL be high in IDLE and RUN and low in CLEAR and LOAD.
REQ-017 SHALL capture cmd_data into the reload register on every accepted 01 or 10 command, and SHALL latch the mode (one-shot or periodic).
REQ-018 In IDLE or RUN, an accepted 00 SHALL go to CLEAR, 01 or 10 SHALL go to LOAD, and 11 SHALL go to IDLE.
REQ-019 In IDLE, an accepted 11 SHALL be a no-op.
REQ-020 CLEAR SHALL last one cycle with cnt_m=00, then return to IDLE.
REQ-021 LOAD SHALL last one cycle with cnt_m=10, then go to RUN.
REQ-022 In IDLE, cnt_m SHALL be 01 and cnt_CI_n SHALL be 1.
REQ-023 In RUN, cnt_m SHALL be 11 and cnt_CI_n SHALL be the inverse of tick; tick is constantly 1 without the macro.
REQ-024 Expiry SHALL occur on a RUN cycle with cnt_CO_n=0, tick=1 and no command accepted.
REQ-025 On one-shot expiry, cnt_m SHALL be 01 in that cycle and the next state SHALL be IDLE, leaving the counter at all-ones.
REQ-026 On periodic expiry, cnt_m SHALL be 10 in that cycle (combinational from cnt_CO_n) and the state SHALL stay RUN; the period SHALL be 2^WIDTH - cmd_data cycles.
REQ-027 done SHALL be high exactly the cycle after each expiry.
REQ-028 When a command is accepted in the same cycle as expiry, the command SHALL win: no done, and cnt_m follows the current state.
REQ-029 A retrigger (01 or 10 accepted in RUN) SHALL reload with the new cmd_data through LOAD.

Reset
REQ-030 CLR_n low SHALL immediately force state IDLE, cnt_m=01, cnt_CI_n=1, reload register 0 (so cnt_D=0), mode one-shot, done=0, busy=0 and prescaler 0, including mid-RUN.
REQ-031 After release, the first command SHALL be acceptable on the first rising clk edge.

Configuration
REQ-032 Macro TTL74X461_SEQ_PRESCALE_EN defined: an 8-bit prescaler SHALL clear in LOAD and increment each RUN cycle; tick SHALL be 1 only when the prescaler equals PRESCALE, after which it wraps to 0, so each count value lasts PRESCALE+1 cycles.
REQ-033 Macro not defined: no prescaler register SHALL exist, tick SHALL be constantly 1 and PRESCALE SHALL be ignored.

Verification
(Bench drives a WIDTH=8 behavioural counter honouring the cnt_m encoding.)
REQ-034 Reset: CLR_n low -> cnt_m=01, cnt_CI_n=1, cnt_D=0x00, busy=0, done=0, cmd_ready=1.
REQ-035 One-shot 0xFC -> one LOAD cycle; Q goes FC,FD,FE,FF; done pulses once; Q holds FF; busy=0 and cmd_ready=1 thereafter.
REQ-036 Periodic 0xFE -> Q goes FE,FF,FE,FF...; done every 2 cycles; cnt_m=10 on each Q=FF cycle.
REQ-037 Periodic 0x00, abort at Q=0x10 -> cnt_m=01 next cycle; Q holds 0x10 (the counter advanced once on the accept edge); no done.
REQ-038 Clear command with Q=0x55 -> cnt_m=00 for one cycle; Q=0x00; back to IDLE.
REQ-039 CLR_n pulse mid-RUN at Q=0x80 -> outputs reach reset values without a clock edge; Q frozen; done stays 0; with macro and PRESCALE=1, one-shot 0xFE -> each Q value held 2 cycles; done after 4 RUN cycles.
